spm_program_loader: RTL

Bus-master write initiator for the SPM memory unit. It accepts a stream of program/data words over a valid/ready handshake and writes them into consecutive memory addresses, starting at a programmable base address. The processor is held via `cpu_hold` while loading. The block sits between the boot/host interface and the memory unit's `Bus_1`/`address`/`write` port. It also observes `memory_word`, which is a combinational read, for optional readback verification.

---
 rtl/spm_pkg.sv | 16 +
 rtl/spm_loader_csum.sv | 35 +++
 rtl/spm_program_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared SPM package: default memory geometry and the program loader state encoding.
// Used by the memory, processing and loader units.
package spm_pkg;

  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned DEPTH     = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } loader_state_e;

endpackage

// File: rtl/spm_loader_csum.sv
// Modular (2**word_size) accumulator with synchronous clear and enable.
// Ports: clk, rst_n, clr_i (clear, wins over enable), en_i (add din_i), din_i, sum_o (registered sum).
module spm_loader_csum #(
  parameter int unsigned word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [word_size-1:0] din_i,
  output logic [word_size-1:0] sum_o
);

  logic [word_size-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/spm_program_loader.sv
// SPM program loader: streams words from a valid/ready source into consecutive
// memory addresses starting at a latched base, holding the CPU while busy.
// Ports: clk, rst_n, start/base_addr/length (load request), in_valid/in_data/in_ready
// (word stream), mem_address/mem_data/mem_write (memory write port), mem_rdata
// (combinational memory readback), busy, cpu_hold, done (pulse), error (sticky).
// Option SPM_LOADER_VERIFY_EN: adds a readback checksum pass (VERIFY state) and
// the checksum output port.
module spm_program_loader
  import spm_pkg::*;
#(
  parameter int unsigned word_size = WORD_SIZE,
  parameter int unsigned depth     = DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [word_size-1:0] base_addr,
  input  logic [word_size:0]   length,
  input  logic                 in_valid,
  input  logic [word_size-1:0] in_data,
  output logic                 in_ready,
  output logic [word_size-1:0] mem_address,
  output logic [word_size-1:0] mem_data,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_rdata,
  output logic                 busy,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
`ifdef SPM_LOADER_VERIFY_EN
  ,
  output logic [word_size-1:0] checksum
`endif
);

  localparam int unsigned   CW      = word_size + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  loader_state_e        state_q, state_d;
  logic [word_size-1:0] base_q, base_d;
  logic [CW-1:0]        len_q, len_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [word_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] data_q, data_d;
  logic                 wr_q, wr_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 sum_clr_c;
  logic                 ld_en_c;
  logic                 rb_en_c;

`ifdef SPM_LOADER_VERIFY_EN
  logic [word_size-1:0] chk_q, chk_d;
  logic [word_size-1:0] ld_sum_c, rb_sum_c;
  logic [word_size-1:0] rb_final_c;

  // Load-side sum of accepted words and readback-side sum of memory contents.
  spm_loader_csum #(.word_size(word_size)) u_ld_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sum_clr_c),
    .en_i  (ld_en_c),
    .din_i (in_data),
    .sum_o (ld_sum_c)
  );

  spm_loader_csum #(.word_size(word_size)) u_rb_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sum_clr_c),
    .en_i  (rb_en_c),
    .din_i (mem_rdata),
    .sum_o (rb_sum_c)
  );

  // Readback sum including the word being read in the current cycle.
  assign rb_final_c = rb_sum_c + mem_rdata;
  assign checksum   = chk_q;
`else
  // Readback is not used in this build.
  logic unused_rdata_c;
  assign unused_rdata_c = ^mem_rdata;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    err_d     = err_q;
    sum_clr_c = 1'b0;
    ld_en_c   = 1'b0;
    rb_en_c   = 1'b0;
`ifdef SPM_LOADER_VERIFY_EN
    chk_d     = chk_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d     = 1'b0;
          sum_clr_c = 1'b1;
`ifdef SPM_LOADER_VERIFY_EN
          chk_d     = '0;
`endif
          if (length == '0) begin
            state_d = ST_DONE;
          end else if (length > DEPTH_C) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            base_d  = base_addr;
            len_d   = length;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        // in_ready is high for the whole state, so in_valid alone is the handshake.
        if (in_valid) begin
          addr_d  = base_q + word_size'(cnt_q);
          data_d  = in_data;
          wr_d    = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          ld_en_c = 1'b1;
          if (cnt_q == len_q - CW'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
`ifdef SPM_LOADER_VERIFY_EN
        cnt_d   = '0;
        addr_d  = base_q;
        state_d = ST_VERIFY;
`else
        state_d = ST_DONE;
`endif
      end

`ifdef SPM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        rb_en_c = 1'b1;
        addr_d  = addr_q + word_size'(1);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == len_q - CW'(1)) begin
          if (rb_final_c != ld_sum_c) begin
            err_d = 1'b1;
          end
          chk_d   = ld_sum_c;
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdy_d  = (state_d == ST_LOAD);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef SPM_LOADER_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

  assign in_ready    = rdy_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_write   = wr_q;
  assign busy        = busy_q;
  assign cpu_hold    = busy_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule
